// File: rtl/accel_isa_pkg.sv
`default_nettype none
// ============================================================================
// accel_isa_pkg : opcodes, instruction field layout and decode FSM states
// Rev 1.0
// ============================================================================
package accel_isa_pkg;

  localparam logic [6:0] OPC_VFP    = 7'h57;
  localparam logic [6:0] OPC_VLOAD  = 7'h07;
  localparam logic [6:0] OPC_VSTORE = 7'h27;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_HALT   = 7'h7F;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opc;
  } instr_fields_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } decode_state_e;

  // imm12 overlays funct7/rs2
  function automatic logic [11:0] imm12_of(input instr_fields_t f);
    return {f.funct7, f.rs2};
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// decode_scoreboard : pending-write bit per vector register, 3 read ports
// Rev 1.0
// ============================================================================
module decode_scoreboard #(
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        set_en,
  input  logic [$clog2(NUM_REGS)-1:0] set_addr,
  input  logic                        clr_en,
  input  logic [$clog2(NUM_REGS)-1:0] clr_addr,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr0,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr1,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr2,
  output logic                        rd_pend0,
  output logic                        rd_pend1,
  output logic                        rd_pend2,
  output logic                        empty_next
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_pending_nxt;

  // Set is applied after clear so a same-register set/clear leaves the bit set
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (set_en) w_set_mask[set_addr] = 1'b1;
    if (clr_en) w_clr_mask[clr_addr] = 1'b1;
    w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  assign rd_pend0   = r_pending[rd_addr0];
  assign rd_pend1   = r_pending[rd_addr1];
  assign rd_pend2   = r_pending[rd_addr2];
  assign empty_next = ~|w_pending_nxt;

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// instruction_decode : decode/issue stage with RAW/WAW scoreboard and run/halt
// Rev 1.0
// ============================================================================
module instruction_decode
  import accel_isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int INSTR_W    = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [INSTR_W-1:0]          instr,
  input  logic [DATA_W-1:0]           rs1_data,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
  input  logic                        exe_ready,
  output logic                        fetch_en,
  output logic                        jump_reg,
  output logic [ADDR_WIDTH-1:0]       jr_pc,
  output logic                        issue_valid,
  output logic [6:0]                  issue_opc,
  output logic [$clog2(NUM_REGS)-1:0] issue_rd,
  output logic [$clog2(NUM_REGS)-1:0] issue_rs1,
  output logic [$clog2(NUM_REGS)-1:0] issue_rs2,
  output logic [9:0]                  issue_funct,
  output logic                        done
);

  localparam int RA_W = $clog2(NUM_REGS);

  decode_state_e r_state;
  logic          r_squash;
  logic          r_issue_valid;
  logic [6:0]    r_issue_opc;
  logic [RA_W-1:0] r_issue_rd, r_issue_rs1, r_issue_rs2;
  logic [9:0]    r_issue_funct;
  logic          r_done;

  instr_fields_t   w_f;
  logic [11:0]     w_imm;
  logic            w_is_vfp, w_is_vload, w_is_vstore, w_is_jalr, w_is_halt, w_is_vec;
  logic            w_p_rs1, w_p_rs2, w_p_rd, w_hazard, w_stall;
  logic            w_accept, w_issue_load, w_issue_valid_nxt, w_sb_empty_next;
  logic [ADDR_WIDTH-1:0] w_target;

  assign w_f         = instr_fields_t'(instr[31:0]);
  assign w_imm       = imm12_of(w_f);
  assign w_is_vfp    = (w_f.opc == OPC_VFP);
  assign w_is_vload  = (w_f.opc == OPC_VLOAD);
  assign w_is_vstore = (w_f.opc == OPC_VSTORE);
  assign w_is_jalr   = (w_f.opc == OPC_JALR);
  assign w_is_halt   = (w_f.opc == OPC_HALT);
  assign w_is_vec    = w_is_vfp | w_is_vload | w_is_vstore;

  decode_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (w_accept & (w_is_vfp | w_is_vload)),
    .set_addr   (RA_W'(w_f.rd)),
    .clr_en     (wb_valid),
    .clr_addr   (wb_addr),
    .rd_addr0   (RA_W'(w_f.rs1)),
    .rd_addr1   (RA_W'(w_f.rs2)),
    .rd_addr2   (RA_W'(w_f.rd)),
    .rd_pend0   (w_p_rs1),
    .rd_pend1   (w_p_rs2),
    .rd_pend2   (w_p_rd),
    .empty_next (w_sb_empty_next)
  );

  // A squashed word is garbage, so it must never raise a hazard
  assign w_hazard = ~r_squash & ((w_is_vfp & (w_p_rs1 | w_p_rs2 | w_p_rd)) |
                                 ((w_is_vload | w_is_vstore) & w_p_rd));
  assign w_stall  = w_hazard | (r_issue_valid & ~exe_ready);
  assign fetch_en = (r_state == RUN) & ~w_stall;
  assign w_accept = fetch_en & ~r_squash;

  assign w_target = ADDR_WIDTH'(rs1_data + {{(DATA_W-12){w_imm[11]}}, w_imm});
  assign jump_reg = w_accept & w_is_jalr;
  assign jr_pc    = jump_reg ? w_target : '0;

  assign w_issue_load      = w_accept & w_is_vec;
  assign w_issue_valid_nxt = w_issue_load | (r_issue_valid & ~exe_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_squash      <= 1'b0;
      r_issue_valid <= 1'b0;
      r_issue_opc   <= '0;
      r_issue_rd    <= '0;
      r_issue_rs1   <= '0;
      r_issue_rs2   <= '0;
      r_issue_funct <= '0;
      r_done        <= 1'b0;
    end else begin
      r_issue_valid <= w_issue_valid_nxt;
      if (w_issue_load) begin
        r_issue_opc   <= w_f.opc;
        r_issue_rd    <= RA_W'(w_f.rd);
        r_issue_rs1   <= RA_W'(w_f.rs1);
        r_issue_rs2   <= RA_W'(w_f.rs2);
        r_issue_funct <= {w_f.funct7, w_f.funct3};
      end
      // Squash holds until fetch actually advances past the discarded word
      if ((r_state == IDLE && start) || jump_reg) r_squash <= 1'b1;
      else if (fetch_en)                         r_squash <= 1'b0;
      case (r_state)
        IDLE:    if (start) r_state <= RUN;
        RUN:     if (w_accept && w_is_halt) r_state <= DRAIN;
        DRAIN: begin
          if (w_sb_empty_next && !w_issue_valid_nxt) begin
            r_state <= HALTED;
            r_done  <= 1'b1;
          end
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign issue_valid = r_issue_valid;
  assign issue_opc   = r_issue_opc;
  assign issue_rd    = r_issue_rd;
  assign issue_rs1   = r_issue_rs1;
  assign issue_rs2   = r_issue_rs2;
  assign issue_funct = r_issue_funct;
  assign done        = r_done;

endmodule
`default_nettype wire
